data_mem_responder: RTL

Multi-cycle data-memory responder that services the pipeline's memory-stage load/store requests. It accepts one request at a time over a valid/ready handshake. It performs RISC-V byte/half/word accesses with func3 encoding, alignment and range checking, and sign/zero extension. It returns read data after a fixed latency and raises stall_req so the hazard logic can freeze the pipeline while an access is outstanding.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/lsu_align.sv | 47 ++++
 rtl/data_mem_responder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: func3 codes, FSM states
// and the legality/alignment checks used by both the top level and lsu_align.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic logic func3_legal(input logic write, input logic [2:0] func3);
    if (write) return (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W);
    return (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W) ||
           (func3 == F3_BU) || (func3 == F3_HU);
  endfunction

  // Size comes from func3[1:0]; halfwords need addr[0]=0, words addr[1:0]=0.
  function automatic logic size_aligned(input logic [2:0] func3, input logic [1:0] lo);
    case (func3[1:0])
      2'b01:   return !lo[0];
      2'b10:   return lo == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: load extraction with sign/zero extension,
// store merge into the old word, and the misalignment flag.
module lsu_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [2:0]  func3,
  input  logic [1:0]  lo,
  output logic [31:0] rdata,
  output logic [31:0] merged,
  output logic        misalign
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{lo, 3'b000} +: 8];
    lane_h = lo[1] ? word[31:16] : word[15:0];
    case (func3)
      F3_B:    rdata = {{24{lane_b[7]}}, lane_b};
      F3_H:    rdata = {{16{lane_h[15]}}, lane_h};
      F3_W:    rdata = word;
      F3_BU:   rdata = {24'b0, lane_b};
      F3_HU:   rdata = {16'b0, lane_h};
      default: rdata = '0;
    endcase
  end

  // Untouched lanes keep the old word so sub-word stores preserve neighbours.
  always_comb begin
    merged = word;
    case (func3)
      F3_B: merged[{lo, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (lo[1]) merged[31:16] = wdata[15:0];
        else       merged[15:0]  = wdata[15:0];
      end
      F3_W:    merged = wdata;
      default: merged = word;
    endcase
  end

  assign misalign = !size_aligned(func3, lo);

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store responder: one request at a time, fixed-latency
// response, array accessed on the edge that enters RESP.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall_req
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem [DEPTH_WORDS];

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_write;
  logic [2:0]  cap_func3;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic        accept;
  logic        enter_resp;
  logic        eff_write;
  logic [2:0]  eff_func3;
  logic [31:0] eff_addr;
  logic [31:0] eff_wdata;
  logic        in_range;
  logic        misalign;
  logic        err;
  logic [IDX_W-1:0] idx;
  logic [31:0] old_word;
  logic [31:0] ld_data;
  logic [31:0] st_word;

  assign accept     = req_valid && req_ready;
  assign enter_resp = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 4'd1));
  assign stall_req  = (state == WAIT) || accept;

  // With single-cycle latency the accept edge is also the RESP entry edge,
  // so the live request fields are what would be captured on that edge.
  assign eff_write = (LATENCY == 1) ? req_write : cap_write;
  assign eff_func3 = (LATENCY == 1) ? req_func3 : cap_func3;
  assign eff_addr  = (LATENCY == 1) ? req_addr  : cap_addr;
  assign eff_wdata = (LATENCY == 1) ? req_wdata : cap_wdata;

  assign in_range = {2'b00, eff_addr[31:2]} < 32'(DEPTH_WORDS);
  assign idx      = eff_addr[IDX_W+1:2];
  assign old_word = mem[idx];
  assign err      = !in_range || misalign || !func3_legal(eff_write, eff_func3);

  lsu_align u_align (
    .word     (old_word),
    .wdata    (eff_wdata),
    .func3    (eff_func3),
    .lo       (eff_addr[1:0]),
    .rdata    (ld_data),
    .merged   (st_word),
    .misalign (misalign)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_write <= req_write;
      cap_func3 <= req_func3;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (enter_resp && eff_write && !err) mem[idx] <= st_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= enter_resp;
      if (enter_resp) begin
        rsp_err   <= err;
        rsp_rdata <= (err || eff_write) ? '0 : ld_data;
      end
      case (state)
        WAIT: begin
          if (cnt == 4'd1) begin
            state     <= RESP;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          if (accept) begin
            cnt       <= 4'(LATENCY - 1);
            state     <= (LATENCY == 1) ? RESP : WAIT;
            req_ready <= (LATENCY == 1);
          end else begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
